// File: rtl/yd_pkg.sv
// Shared Yduck register-file constants and the arbiter's grant record.
package yd_pkg;

    localparam int DW = 16;
    localparam int AW = 4;

    localparam logic [AW-1:0] ZE_ADDR = 4'h0;
    localparam logic [AW-1:0] DK_ADDR = 4'h1;
    localparam logic [AW-1:0] R0_ADDR = 4'h2;
    localparam logic [AW-1:0] PC_ADDR = 4'hF;

    // Index field sized for the largest legal requester count (4).
    typedef struct packed {
        logic       vld;
        logic [1:0] idx;
    } pick_t;

endpackage

// File: rtl/yd_wb_arb_if.sv
// Requester-side write-request bundle: packed per-requester valid/addr/data and ready.
interface yd_wb_arb_if #(
    parameter int NREQ = 3,
    parameter int DW   = yd_pkg::DW,
    parameter int AW   = yd_pkg::AW
);

    logic [NREQ-1:0]    req_valid;
    logic [NREQ*AW-1:0] req_addr;
    logic [NREQ*DW-1:0] req_data;
    logic [NREQ-1:0]    req_ready;

    modport master (output req_valid, output req_addr, output req_data, input req_ready);
    modport slave  (input req_valid, input req_addr, input req_data, output req_ready);

endinterface

// File: rtl/yd_rr_pick2.sv
// Combinational round-robin scan: up to two real grants per cycle, plus the
// address-conflict and PC-conflict masks of the requesters it had to skip.
module yd_rr_pick2
    import yd_pkg::pick_t;
#(
    parameter int            NREQ    = 3,
    parameter int            AW      = yd_pkg::AW,
    parameter logic [AW-1:0] ZE_ADDR = yd_pkg::ZE_ADDR,
    parameter logic [AW-1:0] PC_ADDR = yd_pkg::PC_ADDR
) (
    input  logic [NREQ-1:0]          valid,
    input  logic [NREQ*AW-1:0]       addr,
    input  logic [$clog2(NREQ)-1:0]  rr,
    output logic [NREQ-1:0]          grant,
    output pick_t                    g0,
    output pick_t                    g1,
    output logic [NREQ-1:0]          dup_mask,
    output logic [NREQ-1:0]          pc_mask
);

    localparam int IW = $clog2(NREQ);

    logic [1:0]    n;
    logic          pc_taken;
    logic [AW-1:0] a;
    logic [AW-1:0] first_a;
    logic [IW-1:0] idx;

    always_comb begin
        n        = '0;
        pc_taken = 1'b0;
        a        = '0;
        first_a  = '0;
        idx      = '0;
        grant    = '0;
        dup_mask = '0;
        pc_mask  = '0;
        g0       = '0;
        g1       = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = IW'((int'(rr) + k) % NREQ);
            a   = addr[idx*AW +: AW];
            if (valid[idx]) begin
                // Zero-register writes are swallowed without using a port.
                if (a == ZE_ADDR) begin
                    grant[idx] = 1'b1;
                end else if (n != 2'd2) begin
                    if (n == 2'd1 && a == first_a) begin
                        dup_mask[idx] = 1'b1;
                    end else if (a == PC_ADDR && pc_taken) begin
                        pc_mask[idx] = 1'b1;
                    end else begin
                        grant[idx] = 1'b1;
                        if (n == 2'd0) begin
                            g0.vld  = 1'b1;
                            g0.idx  = 2'(idx);
                            first_a = a;
                        end else begin
                            g1.vld = 1'b1;
                            g1.idx = 2'(idx);
                        end
                        pc_taken = pc_taken | (a == PC_ADDR);
                        n        = n + 2'd1;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/yd_wb_arb.sv
// Write-back arbiter: merges NREQ unit writes onto the register file's two write
// ports and jpc input. YD_WB_ARB_STAT_EN adds per-requester stall counters.
module yd_wb_arb
    import yd_pkg::pick_t;
#(
    parameter int            NREQ    = 3,
    parameter int            DW      = yd_pkg::DW,
    parameter int            AW      = yd_pkg::AW,
    parameter logic [AW-1:0] ZE_ADDR = yd_pkg::ZE_ADDR,
    parameter logic [AW-1:0] PC_ADDR = yd_pkg::PC_ADDR
) (
    input  logic          clk,
    input  logic          rst,
    yd_wb_arb_if.slave    req,
    input  logic          flush,
    input  logic          hold,
    output logic          we0,
    output logic [AW-1:0] waddr0,
    output logic [DW-1:0] din0,
    output logic          we1,
    output logic [AW-1:0] waddr1,
    output logic [DW-1:0] din1,
    output logic          jpc
`ifdef YD_WB_ARB_STAT_EN
    ,
    input  logic [1:0]    stat_sel,
    output logic [15:0]   stat_cnt
`endif
);

    localparam int IW = $clog2(NREQ);

    logic [IW-1:0]   rr_q, rr_d;
    logic            we0_q, we0_d, we1_q, we1_d, jpc_q, jpc_d;
    logic [AW-1:0]   waddr0_q, waddr0_d, waddr1_q, waddr1_d;
    logic [DW-1:0]   din0_q, din0_d, din1_q, din1_d;
    logic            pc_wr;
    logic [NREQ-1:0] grant, dup_mask, pc_mask;
    pick_t           g0, g1;

    yd_rr_pick2 #(
        .NREQ    (NREQ),
        .AW      (AW),
        .ZE_ADDR (ZE_ADDR),
        .PC_ADDR (PC_ADDR)
    ) u_pick (
        .valid    (req.req_valid),
        .addr     (req.req_addr),
        .rr       (rr_q),
        .grant    (grant),
        .g0       (g0),
        .g1       (g1),
        .dup_mask (dup_mask),
        .pc_mask  (pc_mask)
    );

    // Conflict masks are kept on the picker boundary for debug visibility only.
    logic unused_masks;
    assign unused_masks = ^{dup_mask, pc_mask};

    assign req.req_ready = grant & {NREQ{~(flush | rst)}};

    always_comb begin
        rr_d     = rr_q;
        we0_d    = 1'b0;
        we1_d    = 1'b0;
        waddr0_d = waddr0_q;
        din0_d   = din0_q;
        waddr1_d = waddr1_q;
        din1_d   = din1_q;
        pc_wr    = 1'b0;
        // A flush kills this cycle's grants and freezes the rotation.
        if (!flush) begin
            if (g0.vld) begin
                we0_d    = 1'b1;
                waddr0_d = req.req_addr[g0.idx*AW +: AW];
                din0_d   = req.req_data[g0.idx*DW +: DW];
                rr_d     = IW'((int'(g0.idx) + 1) % NREQ);
            end
            if (g1.vld) begin
                we1_d    = 1'b1;
                waddr1_d = req.req_addr[g1.idx*AW +: AW];
                din1_d   = req.req_data[g1.idx*DW +: DW];
                rr_d     = IW'((int'(g1.idx) + 1) % NREQ);
            end
            pc_wr = (we0_d && waddr0_d == PC_ADDR) || (we1_d && waddr1_d == PC_ADDR);
        end
        jpc_d = pc_wr | hold;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_q     <= '0;
            we0_q    <= 1'b0;
            we1_q    <= 1'b0;
            waddr0_q <= '0;
            din0_q   <= '0;
            waddr1_q <= '0;
            din1_q   <= '0;
            jpc_q    <= 1'b0;
        end else begin
            rr_q     <= rr_d;
            we0_q    <= we0_d;
            we1_q    <= we1_d;
            waddr0_q <= waddr0_d;
            din0_q   <= din0_d;
            waddr1_q <= waddr1_d;
            din1_q   <= din1_d;
            jpc_q    <= jpc_d;
        end
    end

    assign we0    = we0_q;
    assign waddr0 = waddr0_q;
    assign din0   = din0_q;
    assign we1    = we1_q;
    assign waddr1 = waddr1_q;
    assign din1   = din1_q;
    assign jpc    = jpc_q;

`ifdef YD_WB_ARB_STAT_EN
    logic [NREQ-1:0][15:0] stall_q, stall_d;

    always_comb begin
        stall_d = stall_q;
        for (int i = 0; i < NREQ; i++) begin
            if (req.req_valid[i] && !req.req_ready[i] && !flush && stall_q[i] != 16'hFFFF)
                stall_d[i] = stall_q[i] + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) stall_q <= '0;
        else     stall_q <= stall_d;
    end

    assign stat_cnt = (32'(stat_sel) < NREQ) ? stall_q[stat_sel] : 16'h0;
`endif

endmodule
